// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a pipeline request port and a
// 1024-word synchronous-command data memory with combinational read data.
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_op/size/sign   load/store, byte/half/word, sign-extend for loads
//   req_addr/wdata     byte address, right-aligned store data
//   resp_valid         one-cycle completion pulse
//   resp_data/err      load result / misalignment flag, zero when not valid
//   MEM                memory command: bit0 read enable, bit1 write enable
//   Addr/Wdata/Rdata   memory word index, write word, read word
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [1:0]  MEM,
  output logic [31:0] Addr,
  output logic [31:0] Wdata,
  input  logic [31:0] Rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        op_q, sign_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        accept, misaligned, mem_active;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val, merged;

  assign accept     = req_valid && (state_q == S_IDLE);
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned)       state_d = S_RESP;
          else if (!req_op)     state_d = S_LOAD;
          else if (req_size[1]) state_d = S_STORE;
          else                  state_d = S_RMW_RD;
        end
      end
      S_LOAD, S_STORE, S_RMW_WR: state_d = S_RESP;
      S_RMW_RD:                  state_d = S_RMW_WR;
      S_RESP:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        sign_q  <= req_sign;
        err_q   <= misaligned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_LOAD || state_q == S_RMW_RD) rdata_q <= Rdata;
    end
  end

  // Lane extraction from the captured read word (little-endian lanes).
  always_comb begin
    byte_v = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    half_v = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sign_q & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{sign_q & half_v[15]}}, half_v};
      default: load_val = rdata_q;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes the new data.
  always_comb begin
    merged = rdata_q;
    case (size_q)
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  assign mem_active = (state_q == S_LOAD) || (state_q == S_STORE) ||
                      (state_q == S_RMW_RD) || (state_q == S_RMW_WR);

  always_comb begin
    MEM   = 2'b00;
    Wdata = '0;
    Addr  = mem_active ? {2'b00, addr_q[31:2]} : '0;
    case (state_q)
      S_LOAD, S_RMW_RD: MEM = 2'b01;
      S_STORE: begin
        MEM   = 2'b10;
        Wdata = wdata_q;
      end
      S_RMW_WR: begin
        MEM   = 2'b10;
        Wdata = merged;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (resp_valid && !err_q && !op_q) ? load_val : '0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: none; the data memory word count is fixed at 1024 and the word index is 10 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline access request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_op  input  1  0 = load, 1 = store.
REQ-007 req_size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is reserved and treated as word.
REQ-008 req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_data  output  32  load result; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned access, valid with resp_valid.
REQ-014 MEM  output  2  data-memory command: bit0 = read enable, bit1 = write enable.
REQ-015 Addr  output  32  data-memory word index, {2'b00, addr[31:2]}; the memory uses bits [9:0].
REQ-016 Wdata  output  32  data-memory write word.
REQ-017 Rdata  input  32  data-memory read word; combinational, valid while MEM[0]=1.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, STORE, RMW_RD, RMW_WR and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid=1 and req_ready=1, and all req_* fields are registered on that edge.
REQ-020 Misaligned requests (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL go IDLE->RESP with resp_err=1 and resp_data=0, and SHALL issue no memory command.
REQ-021 For an aligned load, the FSM SHALL go IDLE->LOAD->RESP.
  - LOAD drives MEM=01.
  - Rdata is registered at the end of LOAD.
REQ-022 For an aligned word store, the FSM SHALL go IDLE->STORE->RESP.
  - STORE drives MEM=10 and Wdata=req_wdata.
REQ-023 For byte and halfword stores, the FSM SHALL go IDLE->RMW_RD->RMW_WR->RESP.
  - RMW_RD drives MEM=01 and registers Rdata.
  - RMW_WR drives MEM=10 with the merged word: only the addressed lane is replaced by the low bits of req_wdata.
REQ-024 Lane selection SHALL be little-endian: byte k occupies bits [8k+7:8k], k = addr[1:0]; halfword lane = addr[1] (bits [15:0] or [31:16]).
REQ-025 Byte and halfword load results SHALL be right-aligned and sign- or zero-extended per req_sign; word loads SHALL ignore req_sign.
REQ-026 RESP SHALL last exactly one cycle with resp_valid=1 and SHALL then return to IDLE; there is no response back-pressure.
REQ-027 Latency from the accept edge to resp_valid SHALL be:
  - 1 cycle for errors;
  - 2 cycles for loads and word stores;
  - 3 cycles for subword stores.
REQ-028 Throughput SHALL be at most one request outstanding; a new request is accepted no earlier than the cycle after RESP.
REQ-029 In IDLE and RESP, MEM SHALL be 00, and Addr and Wdata SHALL be 0; MEM SHALL never be 11.
REQ-030 Addr SHALL be held constant from the first memory-command state through the last one of an access.
REQ-031 resp_data and resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-032 While rst=1, the unit SHALL asynchronously force state=IDLE, MEM=00, Addr=0, Wdata=0, resp_valid=0, resp_data=0, resp_err=0 and all request registers to 0.
REQ-033 Asserting rst in any non-IDLE state SHALL abandon the access with no response.
  - Asserting it during STORE or RMW_WR before the clock edge SHALL cause no memory write.
REQ-034 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-035 Word store then load: store 0xDEADBEEF to addr 0x10, then load word from 0x10.
  - Store: MEM=10 with Addr=4 one cycle after accept; no resp_err.
  - Load: resp_data=0xDEADBEEF two cycles after accept.
REQ-036 Byte store RMW: memory word 4 = 0x11223344; store byte 0xAB to addr 0x12.
  - MEM=01 then MEM=10 with Wdata=0x11AB3344.
  - resp_valid three cycles after accept.
REQ-037 Sub-word loads, memory word 4 = 0x80F17F01:
  - signed byte load at 0x13 -> 0xFFFFFF80;
  - unsigned byte load at 0x13 -> 0x00000080;
  - signed halfword load at 0x10 -> 0x00007F01.
REQ-038 Misaligned accesses: word load at 0x12, or halfword store at 0x11.
  - resp_err=1 and resp_data=0 one cycle after accept.
  - MEM stays 00 throughout.
REQ-039 Reset mid-store: assert rst during STORE (word 0x5555AAAA to addr 0x20).
  - MEM goes 00 immediately and resp_valid never fires.
  - A later load of 0x20 returns the prior value.
  - req_ready=1 in the first cycle after rst deasserts.
